// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32I core.
// One ALU, one unified memory port and the immediate extender are shared
// across several cycles per instruction. This FSM sequences every
// datapath select and enable needed for that sharing.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   op              instr[6:0] from the instruction register (valid from DECODE)
//   mem_ready       memory completes the current memread/memwrite this cycle
//   irwrite         load the instruction register and latch the old PC
//   pcupdate        unconditional PC write
//   branch          PC write qualified by the datapath compare result
//   adrsrc          memory address select: 0=PC, 1=ALUOut
//   memread         memory read request
//   memwrite        memory write request
//   regwrite        register file write
//   alusrca         ALU A select: 00=PC, 01=oldPC, 10=rs1, 11=zero
//   alusrcb         ALU B select: 00=rs2, 01=immext, 10=constant 4
//   aluop           00=add, 01=branch compare, 10=funct-decoded
//   resultsrc       result select: 00=ALUOut, 01=memdata, 10=ALU result
//   immsrc          immediate format: I=000, S=001, B=010, J=011, U=100
//   retire          one-cycle pulse in the final cycle of each instruction
//   illegal         sticky trap flag (held by the terminal ILLEGAL state)
//
// Outputs are decoded combinationally from the state register, op and,
// in the memory wait states only, mem_ready.
module multicycle_controller #(
   parameter int unsigned OPW = 7
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [OPW-1:0] op,
   input  logic           mem_ready,
   output logic           irwrite,
   output logic           pcupdate,
   output logic           branch,
   output logic           adrsrc,
   output logic           memread,
   output logic           memwrite,
   output logic           regwrite,
   output logic [1:0]     alusrca,
   output logic [1:0]     alusrcb,
   output logic [1:0]     aluop,
   output logic [1:0]     resultsrc,
   output logic [2:0]     immsrc,
   output logic           retire,
   output logic           illegal
);

   localparam logic [OPW-1:0] OP_LOAD   = OPW'(7'b0000011);
   localparam logic [OPW-1:0] OP_STORE  = OPW'(7'b0100011);
   localparam logic [OPW-1:0] OP_RTYPE  = OPW'(7'b0110011);
   localparam logic [OPW-1:0] OP_IALU   = OPW'(7'b0010011);
   localparam logic [OPW-1:0] OP_BRANCH = OPW'(7'b1100011);
   localparam logic [OPW-1:0] OP_JAL    = OPW'(7'b1101111);
   localparam logic [OPW-1:0] OP_JALR   = OPW'(7'b1100111);
   localparam logic [OPW-1:0] OP_LUI    = OPW'(7'b0110111);
   localparam logic [OPW-1:0] OP_AUIPC  = OPW'(7'b0010111);

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_LUI      = 4'd8,
      S_ALUWB    = 4'd9,
      S_BRANCH   = 4'd10,
      S_JALR     = 4'd11,
      S_JAL      = 4'd12,
      S_ILLEGAL  = 4'd13
   } state_e;

   state_e state_q, state_d;

   // State register; reset abandons any in-flight instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Next-state and output decode.
   always_comb begin
      state_d   = state_q;
      irwrite   = 1'b0;
      pcupdate  = 1'b0;
      branch    = 1'b0;
      adrsrc    = 1'b0;
      memread   = 1'b0;
      memwrite  = 1'b0;
      regwrite  = 1'b0;
      alusrca   = 2'b00;
      alusrcb   = 2'b00;
      aluop     = 2'b00;
      resultsrc = 2'b00;
      immsrc    = IMM_I;
      retire    = 1'b0;
      illegal   = 1'b0;

      case (state_q)
         // ALU computes PC+4 while the instruction is read from PC.
         S_FETCH: begin
            memread   = 1'b1;
            alusrcb   = 2'b10;
            resultsrc = 2'b10;
            if (mem_ready) begin
               irwrite  = 1'b1;
               pcupdate = 1'b1;
               state_d  = S_DECODE;
            end
         end
         // oldPC+imm precomputes the branch/jal target or the auipc result.
         S_DECODE: begin
            alusrca = 2'b01;
            alusrcb = 2'b01;
            case (op)
               OP_BRANCH: immsrc = IMM_B;
               OP_JAL:    immsrc = IMM_J;
               OP_AUIPC:  immsrc = IMM_U;
               default:   immsrc = IMM_I;
            endcase
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_IALU:           state_d = S_EXECI;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               OP_LUI:            state_d = S_LUI;
               OP_AUIPC:          state_d = S_ALUWB;
               default:           state_d = S_ILLEGAL;
            endcase
         end
         S_MEMADR: begin
            alusrca = 2'b10;
            alusrcb = 2'b01;
            if (op == OP_STORE) begin
               immsrc  = IMM_S;
               state_d = S_MEMWRITE;
            end else begin
               state_d = S_MEMREAD;
            end
         end
         S_MEMREAD: begin
            adrsrc  = 1'b1;
            memread = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            resultsrc = 2'b01;
            regwrite  = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMWRITE: begin
            adrsrc   = 1'b1;
            memwrite = 1'b1;
            if (mem_ready) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_EXECR: begin
            alusrca = 2'b10;
            aluop   = 2'b10;
            state_d = S_ALUWB;
         end
         S_EXECI: begin
            alusrca = 2'b10;
            alusrcb = 2'b01;
            aluop   = 2'b10;
            state_d = S_ALUWB;
         end
         // zero + U-immediate.
         S_LUI: begin
            alusrca = 2'b11;
            alusrcb = 2'b01;
            immsrc  = IMM_U;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            regwrite = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         // Taken/not-taken is resolved in the datapath via the branch enable.
         S_BRANCH: begin
            alusrca = 2'b10;
            aluop   = 2'b01;
            branch  = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         // rs1+imm lands in ALUOut, then JAL reuses it as the new PC.
         S_JALR: begin
            alusrca = 2'b10;
            alusrcb = 2'b01;
            state_d = S_JAL;
         end
         // PC <- ALUOut (target) while the ALU forms oldPC+4 for the link.
         S_JAL: begin
            alusrca  = 2'b01;
            alusrcb  = 2'b10;
            pcupdate = 1'b1;
            state_d  = S_ALUWB;
         end
         S_ILLEGAL: begin
            illegal = 1'b1;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

endmodule
